// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register for Mach-V.
// Carries a control bundle and a data bundle under a valid/ready handshake.
// SKID=1 gives a 2-entry skid buffer with a registered in_ready.
// SKID=0 gives a single register with a pass-through ready.
// Flush and RESET both insert a bubble and zero the control bundle.
module pipe_stage_elastic #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_DATA = 1'b0,
  parameter bit SKID       = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_t;

  // The output register shared by both variants; it always holds the
  // entry currently presented downstream.
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  logic accept;
  logic consume;
  logic clear;

  assign clear   = RESET | Flush;
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // The control bundle is forced to zero on a bubble so downstream write
  // enables can never fire from a stale entry.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

  if (SKID) begin : g_skid

    state_t            state;
    logic              ready_q;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign occupancy = (state == SKIDDED) ? 2'd2 :
                       (state == FULL)    ? 2'd1 : 2'd0;

    // Skid-buffer FSM: ready is registered from the next state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge CLK) begin
      if (clear) begin
        state     <= EMPTY;
        ready_q   <= 1'b1;
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state     <= FULL;
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end
            ready_q <= 1'b1;
          end
          FULL: begin
            if (accept && consume) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
              ready_q   <= 1'b1;
            end else if (accept) begin
              state     <= SKIDDED;
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
              ready_q   <= 1'b0;
            end else if (consume) begin
              state     <= EMPTY;
              main_ctrl <= '0;
              ready_q   <= 1'b1;
            end else begin
              ready_q <= 1'b1;
            end
          end
          SKIDDED: begin
            if (consume) begin
              state     <= FULL;
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
              skid_ctrl <= '0;
              ready_q   <= 1'b1;
            end else begin
              ready_q <= 1'b0;
            end
          end
          default: begin
            state     <= EMPTY;
            main_ctrl <= '0;
            ready_q   <= 1'b1;
          end
        endcase
      end
    end

  end else begin : g_single

    logic valid_q;

    assign in_ready  = out_ready | ~valid_q;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};

    // Single register: a new entry may replace the old one in the same cycle
    // the old one is consumed.
    always_ff @(posedge CLK) begin
      if (clear) begin
        valid_q   <= 1'b0;
        main_ctrl <= '0;
        if (CLEAR_DATA) begin
          main_data <= '0;
        end
      end else if (accept) begin
        valid_q   <= 1'b1;
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (consume) begin
        valid_q   <= 1'b0;
        main_ctrl <= '0;
      end
    end

  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard testbench for pipe_stage_elastic.
// Two instances share one stimulus stream: index 0 is the skid-buffer
// variant (CLEAR_DATA=0), index 1 is the single-register variant
// (CLEAR_DATA=1). Each has its own FIFO reference model.
module tb_pipe_stage_elastic;

  localparam int CW = 16;
  localparam int DW = 32;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ir0, ov0, ir1, ov1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    occ0, occ1;

  int            n_checks = 0;
  int            n_fail   = 0;

  int            cnt [2]        = '{0, 0};
  ent_t          exp_q [2][$];
  logic [DW-1:0] last_d [2];
  bit            last_known [2] = '{1'b0, 1'b0};
  bit            started        = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .SKID(1'b1)) dut_skid (
    .CLK(clk), .RESET(reset), .Flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .SKID(1'b0)) dut_reg (
    .CLK(clk), .RESET(reset), .Flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1)
  );

  // Capacity rule: the skid stage takes input while it holds fewer than two
  // entries; the single register takes input when empty or being drained.
  function automatic bit exp_ready(input int d, input int c, input logic ordy);
    if (d == 0) return (c < 2);
    return (ordy == 1'b1) || (c == 0);
  endfunction

  task automatic compare(input string name, input int d,
                         input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, req, $time);
    end
  endtask

  // Reference model: a FIFO of expected entries updated on each rising edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset || flush) begin
        cnt[d] = 0;
        exp_q[d].delete();
        if (d == 1) begin
          last_d[1]     = '0;
          last_known[1] = 1'b1;
        end
      end else begin
        bit   acc;
        bit   con;
        ent_t e;
        acc = in_valid && exp_ready(d, cnt[d], out_ready);
        con = (cnt[d] > 0) && out_ready;
        if (con) cnt[d]--;
        if (acc) begin
          cnt[d]++;
          e.c = in_ctrl;
          e.d = in_data;
          exp_q[d].push_back(e);
        end
      end
    end
    started = 1'b1;
  end

  task automatic checkOutput(input int d, input logic ir, input logic ov,
                             input logic [CW-1:0] oc, input logic [DW-1:0] od,
                             input logic [1:0] occ);
    ent_t e;
    compare("out_valid", d, 64'(ov), 64'(cnt[d] > 0));
    compare("occupancy", d, 64'(occ), 64'(cnt[d]));
    compare("in_ready", d, 64'(ir), 64'(exp_ready(d, cnt[d], out_ready)));
    if (ov === 1'b1) begin
      if (exp_q[d].size() == 0) begin
        compare("unexpected_entry", d, 64'(1), 64'(0));
      end else begin
        e = exp_q[d][0];
        compare("out_ctrl", d, 64'(oc), 64'(e.c));
        compare("out_data", d, 64'(od), 64'(e.d));
        last_d[d]     = e.d;
        last_known[d] = 1'b1;
        if (out_ready) void'(exp_q[d].pop_front());
      end
    end else begin
      compare("bubble_ctrl", d, 64'(oc), 64'(0));
      if (last_known[d]) compare("held_data", d, 64'(od), 64'(last_d[d]));
    end
  endtask

  // Monitor: samples both DUTs mid-cycle and pops presented entries.
  always @(negedge clk) begin
    if (started) begin
      checkOutput(0, ir0, ov0, oc0, od0, occ0);
      checkOutput(1, ir1, ov1, oc1, od1, occ1);
    end
  end

  task automatic applyStimulus(input bit rst, input bit fl, input bit iv,
                               input logic [CW-1:0] c, input logic [DW-1:0] dt,
                               input bit ordy);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = dt;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with junk on the input.
    applyStimulus(1, 0, 1, 16'hFFFF, 32'h1111_1111, 1);
    applyStimulus(1, 0, 1, 16'hFFFF, 32'h1111_1111, 1);

    // Streaming back-to-back.
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, CW'(i), $urandom, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);

    // Stall into the skid register, then drain.
    applyStimulus(0, 0, 1, 16'd5, $urandom, 0);
    applyStimulus(0, 0, 1, 16'd6, $urandom, 0);
    applyStimulus(0, 0, 0, '0, '0, 0);
    applyStimulus(0, 0, 0, '0, '0, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);

    // Flush while skidded, with a same-cycle input that must be dropped.
    applyStimulus(0, 0, 1, 16'd7, $urandom, 0);
    applyStimulus(0, 0, 1, 16'd8, $urandom, 0);
    applyStimulus(0, 1, 1, 16'd9, $urandom, 0);
    applyStimulus(0, 0, 0, '0, '0, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);

    // Data hold vs. clear across a flush.
    applyStimulus(0, 0, 1, 16'h000A, 32'hDEADBEEF, 0);
    applyStimulus(0, 0, 0, '0, '0, 0);
    applyStimulus(0, 1, 0, '0, '0, 0);
    applyStimulus(0, 0, 0, '0, '0, 0);

    // Single-register replace: blocked while stalled, replaced when drained.
    applyStimulus(0, 0, 1, 16'h000B, $urandom, 0);
    applyStimulus(0, 0, 1, 16'h000C, $urandom, 0);
    applyStimulus(0, 0, 1, 16'h000C, $urandom, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);
    applyStimulus(0, 0, 0, '0, '0, 1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(31) == 0),
                    ($urandom_range(9) < 7), CW'($urandom), $urandom,
                    ($urandom_range(9) < 6));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, '0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
